// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and 12-bit colour layout,
// shared by the scan engine and the page renderers.
package vga_timing_pkg;
    typedef logic [9:0] coord_t;

    localparam coord_t H_ACTIVE     = 10'd640;
    localparam coord_t H_FP         = 10'd16;
    localparam coord_t H_SYNC       = 10'd96;
    localparam coord_t H_BP         = 10'd48;
    localparam coord_t H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam coord_t H_SYNC_START = H_ACTIVE + H_FP;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam coord_t V_ACTIVE     = 10'd480;
    localparam coord_t V_FP         = 10'd10;
    localparam coord_t V_SYNC       = 10'd2;
    localparam coord_t V_BP         = 10'd33;
    localparam coord_t V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t V_SYNC_START = V_ACTIVE + V_FP;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Renderer colour word: blue [11:8], green [7:4], red [3:0].
    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } rgb_t;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register; every stage resets
// asynchronously to RST_VAL so idle sync levels survive reset.
module vga_delay_line #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA scan counters, renderer coordinates, and sync/blank
// delayed by the renderer latency so pins stay aligned with colour.
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_LAT = 1,
    parameter coord_t H_ACT   = H_ACTIVE,
    parameter coord_t H_FRONT = H_FP,
    parameter coord_t H_PULSE = H_SYNC,
    parameter coord_t H_BACK  = H_BP,
    parameter coord_t V_ACT   = V_ACTIVE,
    parameter coord_t V_FRONT = V_FP,
    parameter coord_t V_PULSE = V_SYNC,
    parameter coord_t V_BACK  = V_BP
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic [11:0] pixel_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    localparam coord_t H_LAST = H_ACT + H_FRONT + H_PULSE + H_BACK - 10'd1;
    localparam coord_t V_LAST = V_ACT + V_FRONT + V_PULSE + V_BACK - 10'd1;
    localparam coord_t H_SS   = H_ACT + H_FRONT;
    localparam coord_t H_SE   = H_SS + H_PULSE;
    localparam coord_t V_SS   = V_ACT + V_FRONT;
    localparam coord_t V_SE   = V_SS + V_PULSE;

    coord_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    coord_t x_q, x_d, y_q, y_d;
    logic   fs_q, fs_d;
    logic   de0_q, de0_d, hs0_q, hs0_d, vs0_q, vs0_d;
    logic   de_dl, hs_dl, vs_dl;
    rgb_t   rgb_q, rgb_d;
    logic   hs_q, vs_q;

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        de0_d   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        x_d     = de0_d ? h_cnt_q : '0;
        y_d     = de0_d ? v_cnt_q : '0;
        fs_d    = de0_d && (h_cnt_q == '0) && (v_cnt_q == '0);
        hs0_d   = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
        vs0_d   = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
        rgb_d   = de_dl ? rgb_t'(pixel_data) : '0;
    end

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            de0_q   <= 1'b0;
            hs0_q   <= 1'b1;
            vs0_q   <= 1'b1;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            de0_q   <= de0_d;
            hs0_q   <= hs0_d;
            vs0_q   <= vs0_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_dl;
            vs_q    <= vs_dl;
        end
    end

    // Sync/blank wait here while the renderer turns x/y into pixel_data.
    vga_delay_line #(
        .WIDTH  (3),
        .DEPTH  (PIX_LAT),
        .RST_VAL(3'b011)
    ) u_align (
        .clk_i(vga_clk),
        .rst_i(vga_rst),
        .d_i  ({de0_q, hs0_q, vs0_q}),
        .q_o  ({de_dl, hs_dl, vs_dl})
    );

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign frame_start = fs_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
endmodule
